// File: rtl/bitonic_merge_feeder.sv
// Feeds a bitonic half merger from two sorted bundle streams: picks the head with the smaller max key,
// pairs it with the previously issued bundle, and closes each run with o_last, a bubble, then o_done.
module bitonic_merge_feeder #(
    parameter int DATA_WIDTH   = 32,
    parameter int KEY_WIDTH    = 32,
    parameter int BUNDLE_WIDTH = 16
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_a_valid,
    input  logic [DATA_WIDTH*BUNDLE_WIDTH-1:0] i_a_bundle,
    input  logic                               i_a_last,
    output logic                               o_a_ready,
    input  logic                               i_b_valid,
    input  logic [DATA_WIDTH*BUNDLE_WIDTH-1:0] i_b_bundle,
    input  logic                               i_b_last,
    output logic                               o_b_ready,
    output logic                               o_valid,
    output logic [DATA_WIDTH*BUNDLE_WIDTH-1:0] o_bundle_0,
    output logic [DATA_WIDTH*BUNDLE_WIDTH-1:0] o_bundle_1,
    output logic                               o_last,
    output logic                               o_done
);

    localparam int BW      = DATA_WIDTH * BUNDLE_WIDTH;
    localparam int MAX_LSB = (BUNDLE_WIDTH - 1) * DATA_WIDTH;

    typedef enum logic [1:0] {
        MERGE,
        DRAIN_A,
        DRAIN_B,
        FLUSH
    } state_t;

    state_t state, state_next;

    logic [KEY_WIDTH-1:0] max_a, max_b;
    logic                 a_ready, b_ready;
    logic                 pop, final_pop;
    logic [BW-1:0]        pop_bundle;
    logic                 run_active;
    logic                 done_pending;

    // Bundles are sorted ascending, so the top record carries the bundle's max key.
    assign max_a = i_a_bundle[MAX_LSB +: KEY_WIDTH];
    assign max_b = i_b_bundle[MAX_LSB +: KEY_WIDTH];

    always_comb begin
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        state_next = state;
        case (state)
            MERGE: begin
                if (i_a_valid && i_b_valid) begin
                    if (max_a <= max_b) begin
                        a_ready = 1'b1;
                        if (i_a_last) state_next = DRAIN_B;
                    end else begin
                        b_ready = 1'b1;
                        if (i_b_last) state_next = DRAIN_A;
                    end
                end
            end
            DRAIN_A: begin
                a_ready = i_a_valid;
                if (i_a_valid && i_a_last) state_next = FLUSH;
            end
            DRAIN_B: begin
                b_ready = i_b_valid;
                if (i_b_valid && i_b_last) state_next = FLUSH;
            end
            FLUSH:   state_next = MERGE;
            default: state_next = MERGE;
        endcase
    end

    assign o_a_ready  = a_ready & i_rst_n;
    assign o_b_ready  = b_ready & i_rst_n;
    assign pop        = a_ready | b_ready;
    assign final_pop  = pop && (state_next == FLUSH);
    assign pop_bundle = a_ready ? i_a_bundle : i_b_bundle;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= MERGE;
        else          state <= state_next;
    end

    // run_active tells the next issue whether o_bundle_0 belongs to the same run;
    // o_done trails the FLUSH cycle by two edges so it lands after the bubble.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid      <= 1'b0;
            o_last       <= 1'b0;
            o_done       <= 1'b0;
            o_bundle_0   <= '0;
            o_bundle_1   <= '0;
            run_active   <= 1'b0;
            done_pending <= 1'b0;
        end else begin
            o_valid      <= pop;
            o_last       <= final_pop;
            done_pending <= (state == FLUSH);
            o_done       <= done_pending;
            if (pop) begin
                o_bundle_0 <= pop_bundle;
                o_bundle_1 <= run_active ? o_bundle_0 : '0;
                run_active <= !final_pop;
            end else if (state == FLUSH) begin
                o_bundle_1 <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bitonic_merge_feeder.sv
// Directed bench for bitonic_merge_feeder with 2-record, 8-bit bundles; streams are small
// arrays whose head advances whenever the DUT's ready was high at the clock edge.
module tb_bitonic_merge_feeder;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_a_valid, i_a_last, o_a_ready;
    logic [15:0] i_a_bundle;
    logic        i_b_valid, i_b_last, o_b_ready;
    logic [15:0] i_b_bundle;
    logic        o_valid, o_last, o_done;
    logic [15:0] o_bundle_0, o_bundle_1;

    int checks = 0;
    int errors = 0;

    logic [15:0] a_mem [8];
    logic        a_last_mem [8];
    logic [15:0] b_mem [8];
    logic        b_last_mem [8];
    int          a_cnt, a_idx, b_cnt, b_idx;
    logic        a_en, b_en;

    bitonic_merge_feeder #(
        .DATA_WIDTH  (8),
        .KEY_WIDTH   (8),
        .BUNDLE_WIDTH(2)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_a_valid (i_a_valid),
        .i_a_bundle(i_a_bundle),
        .i_a_last  (i_a_last),
        .o_a_ready (o_a_ready),
        .i_b_valid (i_b_valid),
        .i_b_bundle(i_b_bundle),
        .i_b_last  (i_b_last),
        .o_b_ready (o_b_ready),
        .o_valid   (o_valid),
        .o_bundle_0(o_bundle_0),
        .o_bundle_1(o_bundle_1),
        .o_last    (o_last),
        .o_done    (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic drive_heads();
        i_a_valid  = a_en && (a_idx < a_cnt);
        i_a_bundle = (a_idx < a_cnt) ? a_mem[a_idx] : 16'h0;
        i_a_last   = (a_idx < a_cnt) ? a_last_mem[a_idx] : 1'b0;
        i_b_valid  = b_en && (b_idx < b_cnt);
        i_b_bundle = (b_idx < b_cnt) ? b_mem[b_idx] : 16'h0;
        i_b_last   = (b_idx < b_cnt) ? b_last_mem[b_idx] : 1'b0;
    endtask

    task automatic clear_streams();
        a_cnt = 0; a_idx = 0; b_cnt = 0; b_idx = 0;
        a_en  = 1'b1; b_en = 1'b1;
    endtask

    task automatic push_a(input logic [15:0] bundle, input logic last);
        a_mem[a_cnt] = bundle; a_last_mem[a_cnt] = last; a_cnt++;
    endtask

    task automatic push_b(input logic [15:0] bundle, input logic last);
        b_mem[b_cnt] = bundle; b_last_mem[b_cnt] = last; b_cnt++;
    endtask

    // One clock: remember the handshakes seen before the edge, then advance the stream heads.
    task automatic tick();
        logic ra, rb;
        ra = o_a_ready;
        rb = o_b_ready;
        @(posedge i_clk);
        #1;
        if (ra) a_idx++;
        if (rb) b_idx++;
        drive_heads();
        #1;
    endtask

    task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_ready(input string tag, input logic ra, input logic rb);
        check_value({tag, ".a_ready"}, {31'b0, o_a_ready}, {31'b0, ra});
        check_value({tag, ".b_ready"}, {31'b0, o_b_ready}, {31'b0, rb});
    endtask

    task automatic check_output(input string tag, input logic v, input logic [15:0] b0,
                                input logic [15:0] b1, input logic l, input logic d);
        check_value({tag, ".valid"},    {31'b0, o_valid}, {31'b0, v});
        check_value({tag, ".bundle_0"}, {16'b0, o_bundle_0}, {16'b0, b0});
        check_value({tag, ".bundle_1"}, {16'b0, o_bundle_1}, {16'b0, b1});
        check_value({tag, ".last"},     {31'b0, o_last}, {31'b0, l});
        check_value({tag, ".done"},     {31'b0, o_done}, {31'b0, d});
    endtask

    // A=[1,3],[5,9]  B=[2,4],[6,7]: pops A0, B0, B1, then A1 while draining A.
    task automatic run_basic_merge(input string tag);
        clear_streams();
        push_a(16'h0301, 1'b0); push_a(16'h0905, 1'b1);
        push_b(16'h0402, 1'b0); push_b(16'h0706, 1'b1);
        drive_heads();
        #1;
        check_ready({tag, ".c0"}, 1'b1, 1'b0); tick();
        check_output({tag, ".i0"}, 1'b1, 16'h0301, 16'h0000, 1'b0, 1'b0);
        check_ready({tag, ".c1"}, 1'b0, 1'b1); tick();
        check_output({tag, ".i1"}, 1'b1, 16'h0402, 16'h0301, 1'b0, 1'b0);
        check_ready({tag, ".c2"}, 1'b0, 1'b1); tick();
        check_output({tag, ".i2"}, 1'b1, 16'h0706, 16'h0402, 1'b0, 1'b0);
        check_ready({tag, ".c3"}, 1'b1, 1'b0); tick();
        check_output({tag, ".i3"}, 1'b1, 16'h0905, 16'h0706, 1'b1, 1'b0);
        check_ready({tag, ".flush"}, 1'b0, 1'b0); tick();
        check_output({tag, ".bubble"}, 1'b0, 16'h0905, 16'h0000, 1'b0, 1'b0);
        tick();
        check_output({tag, ".done"}, 1'b0, 16'h0905, 16'h0000, 1'b0, 1'b1);
        tick();
        check_output({tag, ".idle"}, 1'b0, 16'h0905, 16'h0000, 1'b0, 1'b0);
    endtask

    initial begin
        $display("[TB] bitonic_merge_feeder directed test");
        i_rst_n = 1'b0;
        clear_streams();
        push_a(16'h0301, 1'b1);
        push_b(16'h0402, 1'b1);
        drive_heads();
        #2;
        check_ready("reset", 1'b0, 1'b0);
        check_output("reset", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        @(posedge i_clk);
        @(posedge i_clk);
        #2;
        i_rst_n = 1'b1;
        #1;

        run_basic_merge("s1");

        // Tie on max key goes to A; B then drains its single bundle.
        clear_streams();
        push_a(16'h0500, 1'b1);
        push_b(16'h0501, 1'b1);
        drive_heads();
        #1;
        check_ready("s2.c0", 1'b1, 1'b0); tick();
        check_output("s2.i0", 1'b1, 16'h0500, 16'h0000, 1'b0, 1'b0);
        check_ready("s2.c1", 1'b0, 1'b1); tick();
        check_output("s2.i1", 1'b1, 16'h0501, 16'h0500, 1'b1, 1'b0);
        tick();
        check_output("s2.bubble", 1'b0, 16'h0501, 16'h0000, 1'b0, 1'b0);
        tick();
        check_output("s2.done", 1'b0, 16'h0501, 16'h0000, 1'b0, 1'b1);

        // B withheld for three cycles: no selection may happen on A alone.
        clear_streams();
        push_a(16'h0301, 1'b1);
        push_b(16'h0402, 1'b1);
        b_en = 1'b0;
        drive_heads();
        #1;
        for (int i = 0; i < 3; i++) begin
            check_ready("s3.stall", 1'b0, 1'b0); tick();
            check_output("s3.stall", 1'b0, 16'h0501, 16'h0000, 1'b0, 1'b0);
        end
        b_en = 1'b1;
        drive_heads();
        #1;
        check_ready("s3.c0", 1'b1, 1'b0); tick();
        check_output("s3.i0", 1'b1, 16'h0301, 16'h0000, 1'b0, 1'b0);
        check_ready("s3.c1", 1'b0, 1'b1); tick();
        check_output("s3.i1", 1'b1, 16'h0402, 16'h0301, 1'b1, 1'b0);
        tick();
        check_output("s3.bubble", 1'b0, 16'h0402, 16'h0000, 1'b0, 1'b0);
        tick();
        check_output("s3.done", 1'b0, 16'h0402, 16'h0000, 1'b0, 1'b1);

        // Two runs back to back: run 2 heads are waiting as soon as run 1 ends.
        clear_streams();
        push_a(16'h0301, 1'b1); push_a(16'h0807, 1'b1);
        push_b(16'h0402, 1'b1); push_b(16'h0906, 1'b1);
        drive_heads();
        #1;
        check_ready("s4.c0", 1'b1, 1'b0); tick();
        check_output("s4.i0", 1'b1, 16'h0301, 16'h0000, 1'b0, 1'b0);
        check_ready("s4.c1", 1'b0, 1'b1); tick();
        check_output("s4.i1", 1'b1, 16'h0402, 16'h0301, 1'b1, 1'b0);
        check_ready("s4.flush", 1'b0, 1'b0); tick();
        check_output("s4.bubble", 1'b0, 16'h0402, 16'h0000, 1'b0, 1'b0);
        check_ready("s4.c2", 1'b1, 1'b0); tick();
        check_output("s4.i2", 1'b1, 16'h0807, 16'h0000, 1'b0, 1'b1);
        check_ready("s4.c3", 1'b0, 1'b1); tick();
        check_output("s4.i3", 1'b1, 16'h0906, 16'h0807, 1'b1, 1'b0);
        tick();
        check_output("s4.bubble2", 1'b0, 16'h0906, 16'h0000, 1'b0, 1'b0);
        tick();
        check_output("s4.done2", 1'b0, 16'h0906, 16'h0000, 1'b0, 1'b1);

        // Reset lands between edges while A is draining.
        clear_streams();
        push_a(16'h0301, 1'b0); push_a(16'h0905, 1'b1);
        push_b(16'h0402, 1'b1);
        drive_heads();
        #1;
        check_ready("s5.c0", 1'b1, 1'b0); tick();
        check_output("s5.i0", 1'b1, 16'h0301, 16'h0000, 1'b0, 1'b0);
        check_ready("s5.c1", 1'b0, 1'b1); tick();
        check_output("s5.i1", 1'b1, 16'h0402, 16'h0301, 1'b0, 1'b0);
        check_ready("s5.drain", 1'b1, 1'b0);
        i_rst_n = 1'b0;
        #1;
        check_ready("s5.rst", 1'b0, 1'b0);
        check_output("s5.rst", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();
        check_output("s5.rst_hold", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        i_rst_n = 1'b1;
        clear_streams();
        drive_heads();
        #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("s5.post", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        end
        run_basic_merge("s5.rerun");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
